// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial ALU units: FSM encodings and the default datapath width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ALU_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit combinational full adder cell, reused by the serial ALU units.
module FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one FullAdder evaluated LSB-first over WIDTH cycles, carry held in a flop.
// Operands and results move through independent valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cout;
    logic             r_ovf;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    FullAdder u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last = (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)   w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_sum_sh <= {w_fa_sum, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    // r_carry here is the carry into the MSB
                    if (w_last) begin
                        r_cout <= w_fa_cout;
                        r_ovf  <= r_carry ^ w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum_sh;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes arithmetic expectations, monitor pops and compares.
module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int N_RAND = 2500;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   or_mode = 0;   // 0: always ready, 1: random stalls, 2: held off

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) < 55);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                   input logic xc, input int acc);
        exp_t e;
        int unsigned full;
        full   = int'(xa) + int'(xb) + int'(xc);
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (xa[WIDTH-1] == xb[WIDTH-1]) && (e.sum[WIDTH-1] != xa[WIDTH-1]);
        e.acc  = acc;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        bit ok = 0;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        cin = xc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                sb.push_back(model(xa, xb, xc, cyc + 1));
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) fail_now("accept_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("drain_wait");
    endtask

    initial begin : monitor
        bit   prev_v = 0;
        bit   rel = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
                rel = 0;
                continue;
            end
            if (rel) begin
                chk("release_in_ready", in_ready, 1);
                chk("release_out_valid", out_valid, 0);
                rel = 0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = sb[0];
                    if (!prev_v) chk("latency", cyc - e.acc, WIDTH);
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
                    chk("overflow", overflow, e.ovf);
                    chk("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        rel = 1;
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        bit               seen;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_overflow", overflow, 0);
        @(posedge clk);
        #1;

        // basic and carry/overflow corners
        or_mode = 0;
        issue(8'h0F, 8'h01, 1'b0); drain();
        issue(8'hFF, 8'h01, 1'b0); drain();
        issue(8'h7F, 8'h01, 1'b0); drain();
        issue(8'h80, 8'h80, 1'b0); drain();
        issue(8'h00, 8'h00, 1'b1); drain();

        // back-pressure: result must stay put while held off
        or_mode = 2;
        issue(8'h12, 8'h34, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("bp_out_valid_wait");
        repeat (5) @(posedge clk);
        #1;
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        or_mode = 0;
        drain();

        // in_valid during SHIFT must be ignored
        issue(8'h01, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // reset in the middle of an operation
        issue(8'hF0, 8'h0F, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_sum", sum, 0);
        chk("rst_mid_cout", cout, 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        issue(8'h03, 8'h04, 1'b0);
        drain();

        // randomized operands with random downstream stalls, back-to-back issue
        or_mode = 1;
        for (int n = 0; n < N_RAND; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            issue(ra, rb, rc);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        or_mode = 0;
        drain();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
